sw_debounce: RTL

Per-bit switch conditioner sitting directly upstream of the `led` block: it takes the raw board slide-switch inputs, synchronises them into `clk`, and filters out contact bounce. It drives the clean `sw` bus consumed by `led`, plus single-cycle rise/fall strobes for any downstream logic that must react to a switch toggle.

---
 rtl/sw_debounce_pkg.sv | 12 +
 rtl/debounce_bit.sv | 75 +++++++
 rtl/sw_debounce.sv | 41 ++++
 3 files changed

// File: rtl/sw_debounce_pkg.sv
// Shared definitions for the switch debouncer: FSM encodings and CNT_MAX defaults.
package sw_debounce_pkg;

   // Per-bit FSM state encodings
   localparam logic [0:0] ST_STABLE   = 1'b0;
   localparam logic [0:0] ST_SETTLING = 1'b1;

   // 10 ms at 100 MHz for hardware builds; a short window keeps simulation fast
   localparam int CNT_MAX_SYN = 1_000_000;
   localparam int CNT_MAX_SIM = 4;

endpackage

// File: rtl/debounce_bit.sv
// Single switch bit: synchroniser chain, settle counter, two-state FSM and edge pulses.
module debounce_bit
   import sw_debounce_pkg::*;
#(
   parameter int CNT_MAX     = CNT_MAX_SYN,
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic sw_in,
   output logic sw_out,
   output logic sw_rise,
   output logic sw_fall,
   output logic accept
);

   localparam int             CW       = $clog2(CNT_MAX);
   localparam logic [CW-1:0]  CNT_LAST = CW'(CNT_MAX - 1);

   logic [SYNC_STAGES-1:0] sync;
   logic                   s;
   logic [0:0]             state;
   logic [CW-1:0]          cnt;

   assign s = sync[SYNC_STAGES-1];

   // Accept fires on the edge that completes CNT_MAX consecutive differing samples;
   // exported so the top can register the OR of all pulses in the same cycle.
   assign accept = (state == ST_SETTLING) && (s != sw_out) && (cnt == CNT_LAST);

   // Synchroniser: shift the raw pin into the clock domain
   always_ff @(posedge clk) begin
      if (!rst) sync <= '0;
      else      sync <= {sync[SYNC_STAGES-2:0], sw_in};
   end

   // Settle FSM: qualify a new level, bounce-back restarts from zero
   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= ST_STABLE;
         cnt     <= '0;
         sw_out  <= 1'b0;
         sw_rise <= 1'b0;
         sw_fall <= 1'b0;
      end else begin
         sw_rise <= 1'b0;
         sw_fall <= 1'b0;
         case (state)
            ST_STABLE: begin
               if (s != sw_out) begin
                  state <= ST_SETTLING;
                  cnt   <= CW'(1);
               end else begin
                  cnt <= '0;
               end
            end
            ST_SETTLING: begin
               if (s == sw_out) begin
                  state <= ST_STABLE;
                  cnt   <= '0;
               end else if (accept) begin
                  sw_out  <= s;
                  sw_rise <= s;
                  sw_fall <= ~s;
                  cnt     <= '0;
                  state   <= ST_STABLE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/sw_debounce.sv
// Switch conditioner: WIDTH independent debounce_bit lanes plus a registered any-change flag.
module sw_debounce
   import sw_debounce_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int CNT_MAX     = CNT_MAX_SYN,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sw_in,
   output logic [WIDTH-1:0] sw_out,
   output logic [WIDTH-1:0] sw_rise,
   output logic [WIDTH-1:0] sw_fall,
   output logic             sw_changed
);

   logic [WIDTH-1:0] accept;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      debounce_bit #(
         .CNT_MAX     (CNT_MAX),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_bit (
         .clk     (clk),
         .rst     (rst),
         .sw_in   (sw_in[i]),
         .sw_out  (sw_out[i]),
         .sw_rise (sw_rise[i]),
         .sw_fall (sw_fall[i]),
         .accept  (accept[i])
      );
   end

   // Any-change flag registered from the same accept terms that load the pulses
   always_ff @(posedge clk) begin
      if (!rst) sw_changed <= 1'b0;
      else      sw_changed <= |accept;
   end

endmodule
